inst_prefetch_buf: RTL and testbench

//  Instruction prefetch stage directly upstream of the fetch stage. Issues sequential

---
 rtl/inst_prefetch_buf_pkg.sv | 7 +
 rtl/inst_prefetch_buf_if.sv | 25 ++
 rtl/inst_prefetch_buf_sync_fifo.sv | 47 ++++
 rtl/inst_prefetch_buf.sv | 103 ++++++++++
 tb/tb_inst_prefetch_buf.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_prefetch_buf_pkg.sv
// Shared CPU constants for the instruction prefetch stage.
package inst_prefetch_buf_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/inst_prefetch_buf_if.sv
// Memory-side req/gnt/rvalid bus plus fetch-side valid/ready bus of the prefetch stage.
interface inst_prefetch_buf_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          ir_valid;
    logic [DW-1:0] ir_o;
    logic [AW-1:0] ir_pc;
    logic [AW-1:0] npc;
    logic          ir_ready;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_o, ir_pc, npc,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );
    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_o, ir_pc, npc,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );
endinterface

// File: rtl/inst_prefetch_buf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with clear; dout shows the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || clear)) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/inst_prefetch_buf.sv
// Sequential instruction prefetcher: credit-limited memory reads, PC-tagged return
// queue presented to fetch, and redirect that flushes and drops in-flight words.
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_update,
    input  logic [AW-1:0]        pc_new,
    inst_prefetch_buf_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [CW:0]   credit_sum;
    logic          grant, ret, keep, pop_q;

    logic [AW-1:0] tag_pc;
    logic          tag_full, tag_empty;
    logic [CW-1:0] tag_count;
    logic [DW-1:0] q_data;
    logic [AW-1:0] q_pc;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count;

    // Queued plus in-flight words may never exceed DEPTH, so returns always find room.
    assign credit_sum       = {1'b0, q_count} + {1'b0, outstanding};
    assign bus.imem_req     = !rst && !pc_update && (credit_sum < (CW+1)'(DEPTH));
    assign bus.imem_addr    = fetch_pc;
    assign grant            = bus.imem_req && bus.imem_gnt;
    assign ret              = bus.imem_rvalid;
    assign keep             = ret && !pc_update && (drop == '0);
    assign pop_q            = bus.ir_valid && bus.ir_ready && !pc_update;
    assign outstanding_next = outstanding + CW'(grant) - CW'(ret);

    sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (pc_update),
        .push  (grant),
        .pop   (keep),
        .din   (fetch_pc),
        .dout  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(DW + AW), .DEPTH(DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (pc_update),
        .push  (keep),
        .pop   (pop_q),
        .din   ({bus.imem_rdata, tag_pc}),
        .dout  ({q_data, q_pc}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign bus.ir_valid = !q_empty;
    assign bus.ir_o     = q_empty ? DW'(NOP) : q_data;
    assign bus.ir_pc    = q_empty ? '0 : q_pc;
    assign bus.npc      = bus.ir_pc + AW'(INSTR_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (pc_update) begin
                fetch_pc <= {pc_new[AW-1:2], 2'b00};
                // Every word still in flight after this edge predates the redirect.
                drop     <= outstanding_next;
            end else begin
                if (grant) fetch_pc <= fetch_pc + AW'(INSTR_BYTES);
                if (ret && drop != '0) drop <= drop - CW'(1);
            end
        end
    end

    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
        ret |-> outstanding != '0);
    a_tag_consistent: assert property (@(posedge clk) disable iff (rst)
        tag_count == outstanding - drop);
    a_tag_room: assert property (@(posedge clk) disable iff (rst)
        grant |-> !tag_full);
    a_tag_present: assert property (@(posedge clk) disable iff (rst)
        keep |-> !tag_empty);
    a_queue_room: assert property (@(posedge clk) disable iff (rst)
        keep |-> (!q_full || pop_q));
endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed and randomized bench for inst_prefetch_buf against a queue-level reference model.
module tb_inst_prefetch_buf;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
        int unsigned cyc;
    } inflight_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_update = 1'b0;
    logic [31:0] pc_new = '0;

    inst_prefetch_buf_if #(.AW(32), .DW(32)) bus ();

    inst_prefetch_buf #(.DEPTH(DEPTH), .AW(32), .DW(32), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_update (pc_update),
        .pc_new    (pc_new),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference model: words in flight (oldest first) and words ready for fetch.
    inflight_t   pend_q[$];
    logic [31:0] out_q[$];
    logic [31:0] next_pc;
    logic [31:0] dut_pop_log[$];
    int unsigned cyc;
    int unsigned dut_grants;
    int unsigned dut_pops;
    int unsigned gnt_pct, rv_pct, rdy_pct;
    bit          armed;
    int          n_checks;
    int          n_fails;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit do_rst, input bit do_upd, input logic [31:0] tgt);
        bit          g, rv, rd, exp_req, popped;
        logic [31:0] hpc;
        inflight_t   e;
        @(negedge clk);
        rst       = do_rst;
        pc_update = do_upd;
        pc_new    = tgt;
        g  = ($urandom_range(99) < gnt_pct);
        rv = !do_rst && pend_q.size() != 0 && pend_q[0].cyc < cyc && ($urandom_range(99) < rv_pct);
        rd = ($urandom_range(99) < rdy_pct);
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_word(pend_q[0].addr) : $urandom;
        bus.ir_ready    = rd;
        #1;
        exp_req = !do_rst && !do_upd && (out_q.size() + pend_q.size() < DEPTH);
        hpc = (out_q.size() != 0) ? out_q[0] : 32'h0;
        if (armed) begin
            check("imem_req", bus.imem_req, exp_req);
            check("imem_addr", bus.imem_addr, next_pc);
            check("ir_valid", bus.ir_valid, out_q.size() != 0);
            check("ir_pc", bus.ir_pc, hpc);
            check("ir_o", bus.ir_o, (out_q.size() != 0) ? mem_word(hpc) : 32'h0);
            check("npc", bus.npc, hpc + 32'd4);
        end
        if (!do_rst) begin
            if (bus.imem_req && bus.imem_gnt) dut_grants++;
            if (bus.ir_valid && bus.ir_ready && !do_upd) begin
                dut_pops++;
                dut_pop_log.push_back(bus.ir_pc);
            end
        end
        @(posedge clk);
        if (do_rst) begin
            pend_q.delete();
            out_q.delete();
            next_pc = RESET_PC;
        end else begin
            popped = out_q.size() != 0 && rd && !do_upd;
            if (popped) void'(out_q.pop_front());
            if (rv) begin
                e = pend_q.pop_front();
                if (e.keep && !do_upd) out_q.push_back(e.addr);
            end
            if (exp_req && g) begin
                pend_q.push_back('{addr: next_pc, keep: 1'b1, cyc: cyc});
                next_pc = next_pc + 32'd4;
            end
            if (do_upd) begin
                out_q.delete();
                foreach (pend_q[i]) pend_q[i].keep = 1'b0;
                next_pc = tgt & ~32'h3;
            end
        end
        cyc++;
    endtask

    task automatic knobs(input int unsigned g, input int unsigned rv, input int unsigned rd);
        gnt_pct = g;
        rv_pct  = rv;
        rdy_pct = rd;
    endtask

    task automatic clear_counts();
        dut_grants = 0;
        dut_pops   = 0;
        dut_pop_log.delete();
    endtask

    initial begin
        logic [31:0] first;
        n_checks = 0;
        n_fails  = 0;
        cyc      = 1;
        armed    = 1'b0;
        next_pc  = RESET_PC;
        knobs(100, 100, 100);
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.ir_ready = 1'b0;

        // Reset state
        cycle(1, 0, 0);
        armed = 1'b1;
        cycle(1, 0, 0);

        // 1: streaming at one word per cycle
        clear_counts();
        repeat (12) cycle(0, 0, 0);
        check("t1_pops", dut_pops, 10);
        check("t1_grants", dut_grants, 12);

        // 2: fetch stalled -> credit limits grants to DEPTH
        cycle(1, 0, 0);
        clear_counts();
        knobs(100, 100, 0);
        repeat (10) cycle(0, 0, 0);
        check("t2_grants_stalled", dut_grants, DEPTH);
        knobs(100, 100, 100);
        cycle(0, 0, 0);
        knobs(100, 100, 0);
        repeat (4) cycle(0, 0, 0);
        check("t2_grants_after_pop", dut_grants, DEPTH + 1);

        // 3: grant withheld, request and address held
        cycle(1, 0, 0);
        clear_counts();
        knobs(0, 100, 100);
        repeat (3) cycle(0, 0, 0);
        check("t3_no_grants", dut_grants, 0);
        knobs(100, 0, 100);
        cycle(0, 0, 0);
        #1 check("t3_addr_after_grant", bus.imem_addr, 32'h4);

        // 4: redirect with two words in flight
        cycle(1, 0, 0);
        knobs(100, 0, 100);
        cycle(0, 1, 32'h10);
        repeat (2) cycle(0, 0, 0);
        cycle(0, 1, 32'h103);
        clear_counts();
        knobs(100, 100, 100);
        repeat (8) cycle(0, 0, 0);
        first = (dut_pop_log.size() != 0) ? dut_pop_log[0] : 32'hxxxx_xxxx;
        check("t4_first_pc", first, 32'h100);

        // 5: back-to-back redirects, last target wins
        cycle(1, 0, 0);
        knobs(100, 0, 100);
        cycle(0, 0, 0);
        cycle(0, 1, 32'h200);
        cycle(0, 1, 32'h300);
        clear_counts();
        knobs(100, 100, 100);
        repeat (8) cycle(0, 0, 0);
        first = (dut_pop_log.size() != 0) ? dut_pop_log[0] : 32'hxxxx_xxxx;
        check("t5_first_pc", first, 32'h300);

        // 6: reset with entries queued
        knobs(100, 100, 0);
        repeat (6) cycle(0, 0, 0);
        #1 check("t6_full_before_rst", bus.ir_valid, 1'b1);
        cycle(1, 0, 0);
        #1;
        check("t6_ir_valid", bus.ir_valid, 1'b0);
        check("t6_imem_addr", bus.imem_addr, RESET_PC);

        // Randomized traffic with redirects and occasional resets
        knobs(70, 60, 60);
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) knobs($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100));
            cycle($urandom_range(199) == 0, $urandom_range(15) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
